// File: rtl/fmad_acc.sv
// Iterative radix-16 multiply followed by an add/subtract/accumulate step.
// Optional saturation of the final add/subtract is enabled by defining FMAD_ACC_SAT_EN.
module fmad_acc #(
    parameter int unsigned WIDTH    = 11,
    parameter int unsigned OUTWIDTH = 2 * WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    mulIn1,
    input  logic [WIDTH-1:0]    mulIn2,
    input  logic [WIDTH-1:0]    addIn,
    input  logic                sub,
    input  logic                accumulate,
    output logic                busy,
    output logic                done,
    output logic [OUTWIDTH-1:0] result,
    output logic                ovf
);

    localparam int unsigned NSTEPS = (WIDTH + 3) / 4;
    localparam int unsigned BPAD   = NSTEPS * 4;
    localparam int unsigned CW     = $clog2(NSTEPS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StAdd,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [OUTWIDTH-1:0] mcand_q, mcand_d;
    logic [BPAD-1:0]     mplier_q, mplier_d;
    logic [OUTWIDTH-1:0] prod_q, prod_d;
    logic [OUTWIDTH-1:0] addend_q, addend_d;
    logic                sub_q, sub_d;
    logic [CW-1:0]       step_q, step_d;
    logic [OUTWIDTH-1:0] result_q, result_d;
    logic                ovf_q, ovf_d;

    logic [OUTWIDTH-1:0] partial;
    logic [OUTWIDTH:0]   sum_ext;
    logic                carry;
    logic [OUTWIDTH-1:0] res_next;

    // The true product fits in OUTWIDTH bits, so truncating each partial product is exact.
    assign partial = mcand_q * OUTWIDTH'(mplier_q[3:0]);

    always_comb begin
        sum_ext = '0;
        if (sub_q) begin
            sum_ext = {1'b0, prod_q} - {1'b0, addend_q};
        end else begin
            sum_ext = {1'b0, prod_q} + {1'b0, addend_q};
        end
        carry = sum_ext[OUTWIDTH];
`ifdef FMAD_ACC_SAT_EN
        if (carry) begin
            res_next = sub_q ? '0 : '1;
        end else begin
            res_next = sum_ext[OUTWIDTH-1:0];
        end
`else
        res_next = sum_ext[OUTWIDTH-1:0];
`endif
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        addend_d = addend_q;
        sub_d    = sub_q;
        step_d   = step_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StMul;
                    mcand_d  = OUTWIDTH'(mulIn1);
                    mplier_d = BPAD'(mulIn2);
                    prod_d   = '0;
                    // The accumulated addend is captured now, so the add sees the pre-start result.
                    addend_d = accumulate ? result_q : OUTWIDTH'(addIn);
                    sub_d    = sub;
                    step_d   = '0;
                end
            end
            StMul: begin
                prod_d   = prod_q + partial;
                mcand_d  = mcand_q << 4;
                mplier_d = mplier_q >> 4;
                step_d   = step_q + 1'b1;
                if (step_q == CW'(NSTEPS - 1)) begin
                    state_d = StAdd;
                end
            end
            StAdd: begin
                result_d = res_next;
                ovf_d    = carry;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            addend_q <= '0;
            sub_q    <= 1'b0;
            step_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            addend_q <= addend_d;
            sub_q    <= sub_d;
            step_q   <= step_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule
